// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction memory geometry and loader state encoding.
package cpu_pkg;

  localparam int unsigned IMEM_ADDR_WIDTH = 10;
  localparam int unsigned IMEM_DEPTH      = 1024;
  localparam int unsigned XLEN            = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StDone,
    StErr
  } loader_state_e;

endpackage

// File: rtl/byte_to_word_packer.sv
// Assembles four bytes, little-endian, into one XLEN word; word_valid pulses
// combinationally with the fourth accepted byte.
module byte_to_word_packer
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            byte_valid,
  input  logic [7:0]      byte_data,
  output logic            word_valid,
  output logic [XLEN-1:0] word
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] buf_q, buf_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= 2'd0;
      buf_q <= 24'd0;
    end else begin
      idx_q <= idx_d;
      buf_q <= buf_d;
    end
  end

  always_comb begin
    idx_d = idx_q;
    buf_d = buf_q;
    if (clear) begin
      idx_d = 2'd0;
    end else if (byte_valid) begin
      idx_d = idx_q + 2'd1;
      unique case (idx_q)
        2'd0: buf_d[7:0]   = byte_data;
        2'd1: buf_d[15:8]  = byte_data;
        2'd2: buf_d[23:16] = byte_data;
        2'd3: buf_d        = buf_q;
      endcase
    end
  end

  // The fourth byte bypasses the buffer straight into the top lane.
  assign word_valid = byte_valid && !clear && (idx_q == 2'd3);
  assign word       = {byte_data, buf_q};

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program into instruction memory one word at a time,
// holding the CPU in reset until the load completes.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  loader_state_e         state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]       mem_wdata_q, mem_wdata_d;

  logic            accept;
  logic [15:0]     header_len;
  logic            last_word;
  logic            pack_clear;
  logic            pack_valid;
  logic            word_valid;
  logic [XLEN-1:0] word;

  byte_to_word_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (pack_clear),
    .byte_valid (pack_valid),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      len_lo_q    <= 8'd0;
      len_q       <= '0;
      word_idx_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign in_ready   = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StData);
  assign accept     = in_valid && in_ready;
  assign pack_valid = accept && (state_q == StData);
  assign header_len = {in_data, len_lo_q};
  assign last_word  = (LEN_WIDTH'(word_idx_q) == len_q - LEN_WIDTH'(1));

  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    word_idx_d  = word_idx_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pack_clear  = 1'b0;
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d    = StLenLo;
          word_idx_d = '0;
          pack_clear = 1'b1;
        end
      end
      StLenLo: begin
        if (accept) begin
          len_lo_d = in_data;
          state_d  = StLenHi;
        end
      end
      StLenHi: begin
        if (accept) begin
          len_d = LEN_WIDTH'(header_len);
          if (header_len == 16'd0) begin
            state_d = StDone;
          end else if (32'(header_len) > DEPTH) begin
            state_d = StErr;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (word_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = word_idx_q;
          mem_wdata_d = word;
        end
        // Retire the word as its write pulse ends; the last one ends the load.
        if (mem_we_q) begin
          word_idx_d = word_idx_q + ADDR_WIDTH'(1);
          if (last_word) begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = (state_q != StDone);
  assign done      = (state_q == StDone);
  assign error     = (state_q == StErr);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of whole loads plus hand sequences for
// reset, ignored start, full-depth load and mid-load reset.
module tb_imem_loader;
  import cpu_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int tests;
  int failed;

  logic [9:0]  wa[$];
  logic [31:0] wd[$];

  typedef struct {
    logic [15:0] n;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          toggle;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t vecs[5];

  imem_loader #(
    .ADDR_WIDTH (10),
    .LEN_WIDTH  (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every high mem_we cycle is one recorded write, so duplicates show up as extras.
  always @(negedge clk) begin
    if (reset_n && mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit tog);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      tests++;
      failed++;
      $display("FAIL byte_accept: in_ready stuck at 0, required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'hEE;
    if (tog) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit tog);
    send_byte(w[7:0], tog);
    send_byte(w[15:8], tog);
    send_byte(w[23:16], tog);
    send_byte(w[31:24], tog);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_prog2(input string tag);
    check({tag, "_count"}, 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      check({tag, "_addr0"}, 32'(wa[0]), 32'd0);
      check({tag, "_data0"}, wd[0], 32'h0000_0013);
      check({tag, "_addr1"}, 32'(wa[1]), 32'd1);
      check({tag, "_data1"}, wd[1], 32'h0010_0093);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
  endtask

  initial begin
    tests    = 0;
    failed   = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    vecs[0] = '{16'd2,    32'h0000_0013, 32'h0010_0093, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{16'd2,    32'h0000_0013, 32'h0010_0093, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{16'd0,    32'h0,         32'h0,         1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'd1025, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1};
    vecs[4] = '{16'd1,    32'hDEAD_BEEF, 32'h0,         1'b1, 1'b1, 1'b0};

    // Reset values, then idle ignores a valid stream.
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    reset_n  = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("idle_ready", 32'(in_ready), 32'd0);
    check("idle_hold", 32'(cpu_hold), 32'd1);

    for (int i = 0; i < 5; i++) begin
      wa.delete();
      wd.delete();
      pulse_start();
      check($sformatf("v%0d_start_ready", i), 32'(in_ready), 32'd1);
      check($sformatf("v%0d_start_done", i), 32'(done), 32'd0);
      check($sformatf("v%0d_start_error", i), 32'(error), 32'd0);
      check($sformatf("v%0d_start_hold", i), 32'(cpu_hold), 32'd1);
      send_byte(vecs[i].n[7:0], vecs[i].toggle);
      send_byte(vecs[i].n[15:8], vecs[i].toggle);
      if (!vecs[i].exp_err) begin
        for (int k = 0; k < int'(vecs[i].n); k++) begin
          send_word((k == 0) ? vecs[i].w0 : vecs[i].w1, vecs[i].toggle);
        end
      end
      settle();
      check($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
      check($sformatf("v%0d_error", i), 32'(error), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_hold", i), 32'(cpu_hold), 32'(!vecs[i].exp_done));
      check($sformatf("v%0d_ready", i), 32'(in_ready), 32'd0);
      check($sformatf("v%0d_count", i), 32'(wa.size()),
            vecs[i].exp_err ? 32'd0 : 32'(vecs[i].n));
      for (int k = 0; k < wa.size() && k < 2; k++) begin
        check($sformatf("v%0d_addr%0d", i, k), 32'(wa[k]), 32'(k));
        check($sformatf("v%0d_data%0d", i, k), wd[k], (k == 0) ? vecs[i].w0 : vecs[i].w1);
      end
    end

    // start during a load must not restart it.
    wa.delete();
    wd.delete();
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(32'h0010_0093, 1'b0);
    settle();
    check_prog2("ign_start");

    // Full-depth load: last write lands at DEPTH-1.
    wa.delete();
    wd.delete();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    for (int k = 0; k < IMEM_DEPTH; k++) begin
      send_word(32'hA500_0000 | 32'(k), 1'b0);
    end
    settle();
    check("full_count", 32'(wa.size()), 32'(IMEM_DEPTH));
    for (int k = 0; k < wa.size(); k++) begin
      check($sformatf("full_addr%0d", k), 32'(wa[k]), 32'(k));
      check($sformatf("full_data%0d", k), wd[k], 32'hA500_0000 | 32'(k));
    end
    check("full_done", 32'(done), 32'd1);
    check("full_hold", 32'(cpu_hold), 32'd0);

    // Reset lands during the first word's write pulse.
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(32'h0000_0013, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_we", 32'(mem_we), 32'd0);
    check("mid_rst_wdata", mem_wdata, 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_hold", 32'(cpu_hold), 32'd1);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_error", 32'(error), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    wa.delete();
    wd.delete();
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(32'h0000_0013, 1'b0);
    send_word(32'h0010_0093, 1'b0);
    settle();
    check_prog2("reload");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
